// File: rtl/ipg_rx_fifo.sv
// Purpose: scrubs IPG-payload idle blocks back to standard idles and queues the extracted payload.
// Latency: recovered block is 1 cycle behind the input. Payload is visible on m_ipg_* the cycle after its block.
// Backpressure: m_ipg_tready stalls the FIFO. A push into a full FIFO with no pop that cycle is dropped and counted.
//
// Ports: clk/rst (sync, active-high); encoded_rx_data/hdr + rx_block_lock in;
//        recovered_rx_data/hdr out to the decoder; m_ipg_tdata/tlen/tvalid/tready payload stream;
//        fifo_level, ipg_drop, ipg_drop_count, ipg_bad_len status.
// Optional: define IPG_RX_STATS_EN to add ipg_rx_count[31:0] and ipg_bad_len_count[15:0].

// Generic FWFT FIFO storage. Writes and reads are pre-qualified by the parent.
// Pointers carry an extra wrap bit, so level = wr - rd covers 0..DEPTH.
module ipg_rx_fifo_buf #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_dat_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_dat_o,
    output logic [AW:0]      level_o
);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_en_i) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (rd_en_i) rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    // Storage is not reset. Stale entries are never visible because the head is gated by level.
    always_ff @(posedge clk) begin
        if (wr_en_i) mem_q[wr_ptr_q[AW-1:0]] <= wr_dat_i;
    end

    assign level_o  = wr_ptr_q - rd_ptr_q;
    assign rd_dat_o = (level_o != '0) ? mem_q[rd_ptr_q[AW-1:0]] : '0;
endmodule

module ipg_rx_fifo #(
    parameter int DATA_WIDTH     = 64,
    parameter int HDR_WIDTH      = 2,
    parameter int FIFO_DEPTH     = 16,
    parameter int DROP_CNT_WIDTH = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [DATA_WIDTH-1:0]           encoded_rx_data,
    input  logic [HDR_WIDTH-1:0]            encoded_rx_hdr,
    input  logic                            rx_block_lock,
    output logic [DATA_WIDTH-1:0]           recovered_rx_data,
    output logic [HDR_WIDTH-1:0]            recovered_rx_hdr,
    output logic [47:0]                     m_ipg_tdata,
    output logic [2:0]                      m_ipg_tlen,
    output logic                            m_ipg_tvalid,
    input  logic                            m_ipg_tready,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic                            ipg_drop,
    output logic [DROP_CNT_WIDTH-1:0]       ipg_drop_count,
    output logic                            ipg_bad_len
`ifdef IPG_RX_STATS_EN
    ,
    output logic [31:0]                     ipg_rx_count,
    output logic [15:0]                     ipg_bad_len_count
`endif
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int EW = 3 + 48;
    localparam logic [DATA_WIDTH-1:0] IDLE_DATA = 'h1E;
    localparam logic [HDR_WIDTH-1:0]  CTRL_HDR  = 'b10;
    localparam logic [LW-1:0]         FULL_LVL  = LW'(FIFO_DEPTH);
    localparam logic [DROP_CNT_WIDTH-1:0] DROP_ONE = 1;

    if (DATA_WIDTH != 64) begin : g_bad_data_width
        $error("ipg_rx_fifo: DATA_WIDTH must be 64");
    end
    if (HDR_WIDTH != 2) begin : g_bad_hdr_width
        $error("ipg_rx_fifo: HDR_WIDTH must be 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("ipg_rx_fifo: FIFO_DEPTH must be a power of two and >= 2");
    end

    // Block classification (combinational, on the sampled input)
    logic [3:0] blk_len;
    logic       is_ipg_ctrl;
    logic       len_legal;
    logic       push_req;
    logic       bad_blk;
    logic       fifo_full;
    logic       pop;
    logic       wr_en;
    logic       drop;
    logic [EW-1:0] head_dat;

    assign blk_len     = encoded_rx_data[11:8];
    // Payload and bad-length blocks share this signature. Both get scrubbed.
    assign is_ipg_ctrl = rx_block_lock
                      && (encoded_rx_hdr == CTRL_HDR)
                      && (encoded_rx_data[7:0] == 8'h1E)
                      && (encoded_rx_data[15:12] == 4'hA);
    assign len_legal   = (blk_len >= 4'd1) && (blk_len <= 4'd6);
    assign push_req    = is_ipg_ctrl && len_legal;
    assign bad_blk     = is_ipg_ctrl && !len_legal;

    assign fifo_full    = (fifo_level == FULL_LVL);
    assign m_ipg_tvalid = (fifo_level != '0);
    assign pop          = m_ipg_tvalid && m_ipg_tready;
    // A same-cycle pop frees the slot, so a push into a full FIFO still succeeds.
    assign wr_en        = push_req && (!fifo_full || pop);
    assign drop         = push_req && fifo_full && !pop;

    ipg_rx_fifo_buf #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_buf (
        .clk      (clk),
        .rst      (rst),
        .wr_en_i  (wr_en),
        .wr_dat_i ({blk_len[2:0], encoded_rx_data[63:16]}),
        .rd_en_i  (pop),
        .rd_dat_o (head_dat),
        .level_o  (fifo_level)
    );

    assign m_ipg_tlen  = head_dat[50:48];
    assign m_ipg_tdata = head_dat[47:0];

    // Registered outputs
    logic [DATA_WIDTH-1:0]     rec_data_q, rec_data_d;
    logic [HDR_WIDTH-1:0]      rec_hdr_q,  rec_hdr_d;
    logic                      drop_q;
    logic                      bad_q;
    logic [DROP_CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        rec_data_d = encoded_rx_data;
        rec_hdr_d  = encoded_rx_hdr;
        if (is_ipg_ctrl) begin
            rec_data_d = IDLE_DATA;
            rec_hdr_d  = CTRL_HDR;
        end
    end

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + DROP_ONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rec_data_q <= IDLE_DATA;
            rec_hdr_q  <= CTRL_HDR;
            drop_q     <= 1'b0;
            bad_q      <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            rec_data_q <= rec_data_d;
            rec_hdr_q  <= rec_hdr_d;
            drop_q     <= drop;
            bad_q      <= bad_blk;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign recovered_rx_data = rec_data_q;
    assign recovered_rx_hdr  = rec_hdr_q;
    assign ipg_drop          = drop_q;
    assign ipg_bad_len       = bad_q;
    assign ipg_drop_count    = drop_cnt_q;

`ifdef IPG_RX_STATS_EN
    logic [31:0] rx_cnt_q,  rx_cnt_d;
    logic [15:0] bad_cnt_q, bad_cnt_d;

    always_comb begin
        rx_cnt_d  = rx_cnt_q;
        bad_cnt_d = bad_cnt_q;
        if (wr_en) rx_cnt_d = rx_cnt_q + 32'd1;
        if (bad_blk && (bad_cnt_q != 16'hFFFF)) bad_cnt_d = bad_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_cnt_q  <= '0;
            bad_cnt_q <= '0;
        end else begin
            rx_cnt_q  <= rx_cnt_d;
            bad_cnt_q <= bad_cnt_d;
        end
    end

    assign ipg_rx_count      = rx_cnt_q;
    assign ipg_bad_len_count = bad_cnt_q;
`endif
endmodule

// File: doc/ipg_rx_fifo.md
# ipg_rx_fifo

Receive-side inter-packet-gap (IPG) side-channel extractor for the 10G BASE-R PHY RX path. It sits between the RX interface block (descrambled, block-locked 64b/66b stream) and the 64b/66b decoder. It recognises idle blocks carrying IPG payload, scrubs them back to standard idle blocks for the decoder, and queues the extracted payload in a parametrised FIFO with an AXI-Stream-style valid/ready output. It is the buffered, back-pressurable successor to the unbuffered per-cycle IPG extractor.

## Interface
Parameters:
- DATA_WIDTH, 64, block data width; only 64 is legal (elaboration error otherwise).
- HDR_WIDTH, 2, sync header width; only 2 is legal.
- FIFO_DEPTH, 16, payload FIFO entries; must be a power of two and ≥2.
- DROP_CNT_WIDTH, 16, width of the saturating drop counter.

Ports:
- clk  in  1  PHY RX clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- encoded_rx_data  in  64  descrambled block payload.
- encoded_rx_hdr  in  2  sync header.
- rx_block_lock  in  1  block lock from the RX interface block; extraction is enabled only while high.
- recovered_rx_data  out  64  block to the decoder, with the IPG payload scrubbed.
- recovered_rx_hdr  out  2  header aligned with recovered_rx_data.
- m_ipg_tdata  out  48  payload bytes; byte 0 is in [7:0].
- m_ipg_tlen  out  3  number of valid bytes, 1..6, counted from byte 0.
- m_ipg_tvalid  out  1  FIFO head is valid.
- m_ipg_tready  in  1  consumer accepts the head.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- ipg_drop  out  1  one-cycle pulse: payload lost because the FIFO was full.
- ipg_drop_count  out  DROP_CNT_WIDTH  saturating count of drops.
- ipg_bad_len  out  1  one-cycle pulse: payload block had an illegal length.

## Operation
Block classes, evaluated on each input cycle:
- Payload block: hdr=2'b10, data[7:0]=8'h1E, data[15:12]=4'hA, len=data[11:8] in 1..6. Payload bytes are data[63:16].
- Bad-length block: same as a payload block, but len is 0 or 7..15.
- Any other block (including a standard idle, where data[63:8]=0).

Response per class:
- Payload block:
  - recovered_rx_data = 64'h0000_0000_0000_001E, recovered_rx_hdr = 2'b10.
  - Push {len, data[63:16]} to the FIFO. Bytes at or above len are pushed as received; the consumer ignores them.
- Bad-length block:
  - Scrubbed to idle exactly as a payload block.
  - No push; ipg_bad_len pulses.
- Other block: passed through unmodified.
- rx_block_lock=0: every block passes through unmodified; no push; no pulses.

FIFO behaviour:
- Write and read pointers are log2(FIFO_DEPTH)+1 bits, with the wrap bit used for full/empty.
- The FIFO is first-word fall-through: m_ipg_tvalid = (level≠0), and tdata/tlen show the head entry.
- A pop occurs when tvalid and tready are both high.
- Full and push without pop: the entry is dropped, ipg_drop pulses, and ipg_drop_count increments, saturating at all-ones.
- Full with push and pop in the same cycle: the push is accepted; no drop; level is unchanged.
- Empty with push and tready high: no pop that cycle; the entry is visible on the next cycle.

## Timing
- recovered_rx_data/hdr: registered, 1-cycle latency from the input.
- A payload block sampled in cycle N is written at the end of N; m_ipg_tvalid is high in cycle N+1.
- ipg_drop and ipg_bad_len are registered and asserted in cycle N+1.
- fifo_level reflects pushes and pops of cycle N in cycle N+1.
- Reset values:
  - recovered_rx_data=64'h1E and recovered_rx_hdr=2'b10 (idle).
  - FIFO empty; m_ipg_tvalid=0; m_ipg_tdata=0; m_ipg_tlen=0; fifo_level=0.
  - ipg_drop=0, ipg_bad_len=0, ipg_drop_count=0.
  - Stats counters are 0.
- Reset mid-operation: FIFO contents are discarded, and the pointers and counters clear on the same edge.
- Sustained throughput: one push and one pop per cycle.

## Configuration
- IPG_RX_STATS_EN defined:
  - Adds output ipg_rx_count [31:0], a wrapping count of accepted pushes.
  - Adds output ipg_bad_len_count [15:0], a saturating count of bad-length blocks.
  - Both reset to 0.
- IPG_RX_STATS_EN undefined: the ports and counters do not exist; all other behaviour is identical.

## Test plan
- Lock high, payload block with len=3, bytes 0x11,0x22,0x33, tready=1:
  - recovered block is 64'h1E with hdr 2'b10, one cycle later.
  - tvalid=1 next cycle with tdata[23:0]=24'h332211 and tlen=3.
- Standard idle, then a data block (hdr=2'b01): both pass through bit-identical with 1-cycle latency; tvalid stays 0.
- tready=0 and 17 payload blocks with FIFO_DEPTH=16:
  - fifo_level reaches 16.
  - The 17th block causes ipg_drop for one cycle and ipg_drop_count=1.
  - Draining then returns entries 1..16 in order.
- FIFO full with tready=1 and a push in the same cycle: no drop; fifo_level stays 16; the new entry appears last on drain.
- Payload block with len=0 and another with len=7:
  - Both are scrubbed to idle, ipg_bad_len pulses twice, and there is no push.
  - With IPG_RX_STATS_EN, ipg_bad_len_count=2.
- Two special cases:
  - Lock low with a payload block: passes through unmodified; no push.
  - rst asserted while the FIFO holds 5 entries: next cycle fifo_level=0, tvalid=0, and recovered is the idle block.
